// File: rtl/avalon_burst_onchip_memory.sv
// Avalon-MM single-port on-chip RAM with burst reads/writes and 1- or 2-cycle read latency.
// Define OCM_PARITY_EN to store one even-parity bit per byte lane and flag mismatches on read.
module avalon_burst_onchip_memory #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 16384,
  parameter int BURST_W = 4,
  parameter int OUT_REG = 0
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                chipselect_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [BURST_W-1:0]  burstcount_i,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [DATA_W-1:0]   writedata_i,
  input  logic [DATA_W/8-1:0] byteenable_i,
  input  logic                clken_i,
  output logic                waitrequest_o,
  output logic [DATA_W-1:0]   readdata_o,
  output logic                readdatavalid_o,
  output logic                parity_err_o
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic [BURST_W-1:0]   rem_q, rem_d;
  logic [BURST_W-1:0]   bc_eff;
  logic                 rd_issue, wr_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic                 rd1_valid_q;
  logic [DATA_W-1:0]    rd1_data_q;
  logic                 perr1;

  function automatic logic [ADDR_W-1:0] incr_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  assign bc_eff = (burstcount_i == '0) ? BURST_W'(1) : burstcount_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  // A write wins over a simultaneous read in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    if (clken_i) begin
      case (state_q)
        IDLE: if (chipselect_i && (write_i || read_i)) begin
          cnt_d = incr_addr(address_i);
          rem_d = bc_eff - 1'b1;
          if (bc_eff != BURST_W'(1)) state_d = write_i ? WR_BURST : RD_BURST;
        end
        RD_BURST: begin
          cnt_d = incr_addr(cnt_q);
          rem_d = rem_q - 1'b1;
          if (rem_q == BURST_W'(1)) state_d = IDLE;
        end
        WR_BURST: if (write_i) begin
          cnt_d = incr_addr(cnt_q);
          rem_d = rem_q - 1'b1;
          if (rem_q == BURST_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    waitrequest_o = (state_q == RD_BURST) ? 1'b1 : ~clken_i;
    rd_issue      = 1'b0;
    wr_en         = 1'b0;
    mem_addr      = cnt_q;
    if (clken_i) begin
      case (state_q)
        IDLE: if (chipselect_i) begin
          mem_addr = address_i;
          wr_en    = write_i;
          rd_issue = read_i & ~write_i;
        end
        RD_BURST: rd_issue = 1'b1;
        WR_BURST: wr_en    = write_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (byteenable_i[b]) mem_q[mem_addr][8*b +: 8] <= writedata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd1_valid_q <= 1'b0;
      rd1_data_q  <= '0;
    end else if (clken_i) begin
      rd1_valid_q <= rd_issue;
      if (rd_issue) rd1_data_q <= mem_q[mem_addr];
    end
  end

`ifdef OCM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] rd1_par_q;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (byteenable_i[b]) par_q[mem_addr][b] <= ^writedata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                rd1_par_q <= '0;
    else if (clken_i && rd_issue)  rd1_par_q <= par_q[mem_addr];
  end

  always_comb begin
    perr1 = 1'b0;
    for (int b = 0; b < NB; b++)
      if ((^rd1_data_q[8*b +: 8]) != rd1_par_q[b]) perr1 = rd1_valid_q;
  end
`else
  assign perr1 = 1'b0;
`endif

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              rd2_valid_q, perr2_q;
      logic [DATA_W-1:0] rd2_data_q;
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          rd2_valid_q <= 1'b0;
          rd2_data_q  <= '0;
          perr2_q     <= 1'b0;
        end else if (clken_i) begin
          rd2_valid_q <= rd1_valid_q;
          rd2_data_q  <= rd1_data_q;
          perr2_q     <= perr1;
        end
      end
      assign readdatavalid_o = rd2_valid_q;
      assign readdata_o      = rd2_data_q;
      assign parity_err_o    = perr2_q;
    end else begin : g_out_direct
      assign readdatavalid_o = rd1_valid_q;
      assign readdata_o      = rd1_data_q;
      assign parity_err_o    = perr1;
    end
  endgenerate

endmodule

// File: tb/tb_avalon_burst_onchip_memory.sv
// Bench for avalon_burst_onchip_memory: two instances (1- and 2-cycle latency) share one bus,
// a transaction-level reference model checks every cycle, plus directed table and corner sequences.
module tb_avalon_burst_onchip_memory;
  localparam int AW  = 8;
  localparam int DEP = 200;

  logic        clk, rst_n, cs, rd, wr, clken;
  logic [7:0]  addr;
  logic [3:0]  bc, be;
  logic [31:0] wd;
  logic        wq0, rdv0, perr0, wq1, rdv1, perr1;
  logic [31:0] rdat0, rdat1;

  int checks = 0;
  int errors = 0;
  bit rnd = 0;
  bit par_flip = 0;

  avalon_burst_onchip_memory #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEP), .BURST_W(4), .OUT_REG(0)) u0 (
    .clk_i(clk), .reset_n_i(rst_n), .chipselect_i(cs), .address_i(addr), .burstcount_i(bc),
    .read_i(rd), .write_i(wr), .writedata_i(wd), .byteenable_i(be), .clken_i(clken),
    .waitrequest_o(wq0), .readdata_o(rdat0), .readdatavalid_o(rdv0), .parity_err_o(perr0));

  avalon_burst_onchip_memory #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEP), .BURST_W(4), .OUT_REG(1)) u1 (
    .clk_i(clk), .reset_n_i(rst_n), .chipselect_i(cs), .address_i(addr), .burstcount_i(bc),
    .read_i(rd), .write_i(wr), .writedata_i(wd), .byteenable_i(be), .clken_i(clken),
    .waitrequest_o(wq1), .readdata_o(rdat1), .readdatavalid_o(rdv1), .parity_err_o(perr1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; logic [31:0] d; } ret_t;
  ret_t        q0[$], q1[$];
  logic [31:0] mref [DEP];
  int mode = 0;   // 0 idle, 1 read burst in progress, 2 write burst in progress
  int ptr = 0, left = 0, ncyc = 0;
  bit ev0, ev1;

  task automatic m_start(input int a);
    ptr  = (a + 1) % DEP;
    left = ((bc == 0) ? 1 : int'(bc)) - 1;
  endtask

  task automatic m_adv();
    ptr  = (ptr + 1) % DEP;
    left = left - 1;
  endtask

  task automatic m_write(input int a);
    for (int b = 0; b < 4; b++)
      if (be[b]) mref[a][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic m_read(input int a);
    q0.push_back('{ncyc + 1, mref[a]});
    q1.push_back('{ncyc + 2, mref[a]});
  endtask

  task automatic m_step();
    case (mode)
      0: if (cs && wr) begin
           m_write(int'(addr)); m_start(int'(addr)); mode = (left > 0) ? 2 : 0;
         end else if (cs && rd) begin
           m_read(int'(addr)); m_start(int'(addr)); mode = (left > 0) ? 1 : 0;
         end
      1: begin
           m_read(ptr); m_adv(); if (left == 0) mode = 0;
         end
      default: if (wr) begin
           m_write(ptr); m_adv(); if (left == 0) mode = 0;
         end
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete(); q1.delete();
      mode = 0; left = 0;
      chk("rst_rdv0", rdv0, 0);   chk("rst_rdv1", rdv1, 0);
      chk("rst_rdat0", rdat0, 0); chk("rst_rdat1", rdat1, 0);
    end else begin
      ev0 = (q0.size() > 0) && (q0[0].due == ncyc);
      ev1 = (q1.size() > 0) && (q1[0].due == ncyc);
      chk("m_rdv0", rdv0, ev0);
      if (ev0) chk("m_rdat0", rdat0, q0[0].d);
      chk("m_rdv1", rdv1, ev1);
      if (ev1) chk("m_rdat1", rdat1, q1[0].d);
      chk("m_wait0", wq0, (mode == 1) ? 1 : !clken);
      chk("m_wait1", wq1, (mode == 1) ? 1 : !clken);
      if (!par_flip) begin
        chk("m_perr0", perr0, 0); chk("m_perr1", perr1, 0);
      end
      if (clken) begin
        if (ev0) void'(q0.pop_front());
        if (ev1) void'(q1.pop_front());
        m_step();
        ncyc++;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic go_idle();
    cs = 0; rd = 0; wr = 0; clken = 1;
  endtask

  task automatic beat(input bit r, input bit w, input logic [7:0] a, input logic [3:0] n,
                      input logic [31:0] d, input logic [3:0] b);
    bit acc;
    acc = 0;
    cs = 1; rd = r; wr = w; addr = a; bc = n; wd = d; be = b;
    for (int i = 0; i < 100 && !acc; i++) begin
      clken = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      @(negedge clk);
      acc = !wq0;
      tick();
    end
    chk("accept", acc, 1);
    go_idle();
  endtask

  task automatic single_read(input string name, input logic [7:0] a, input logic [31:0] exp);
    beat(1, 0, a, 1, 0, 0);
    @(negedge clk);
    chk({name, "_rdv0"}, rdv0, 1); chk({name, "_dat0"}, rdat0, exp);
    tick();
    @(negedge clk);
    chk({name, "_rdv1"}, rdv1, 1); chk({name, "_dat1"}, rdat1, exp);
    tick();
  endtask

  typedef struct {
    bit          is_wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[14];

  int nb;
  int exp_cyc[4];

  initial begin
    tbl[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 8'h05, 32'h11223344, 4'hF, 32'h0};
    tbl[3]  = '{1'b1, 8'h05, 32'hAABBCCDD, 4'h5, 32'h0};
    tbl[4]  = '{1'b0, 8'h05, 32'h0,        4'h0, 32'h11BB33DD};
    tbl[5]  = '{1'b1, 8'h30, 32'h00000000, 4'hF, 32'h0};
    tbl[6]  = '{1'b1, 8'h30, 32'hFFFFFFFF, 4'h8, 32'h0};
    tbl[7]  = '{1'b1, 8'h30, 32'h12345678, 4'h2, 32'h0};
    tbl[8]  = '{1'b0, 8'h30, 32'h0,        4'h0, 32'hFF005600};
    tbl[9]  = '{1'b1, 8'd199, 32'hCAFEF00D, 4'hF, 32'h0};
    tbl[10] = '{1'b0, 8'd199, 32'h0,       4'h0, 32'hCAFEF00D};
    tbl[11] = '{1'b1, 8'h00, 32'h01020304, 4'hF, 32'h0};
    tbl[12] = '{1'b1, 8'h00, 32'hFFFFFFFF, 4'h0, 32'h0};
    tbl[13] = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h01020304};

    rst_n = 0; addr = 0; bc = 0; wd = 0; be = 0;
    go_idle();
    @(negedge clk);
    chk("reset_wait0", wq0, 0); chk("reset_perr0", perr0, 0);
    tick(); tick();
    rst_n = 1;
    tick();

    // known contents everywhere before anything is read
    for (int base = 0; base < DEP; base += 8) begin
      beat(0, 1, 8'(base), 4'd8, $urandom, 4'hF);
      for (int k = 1; k < 8; k++) beat(0, 1, 8'h0, 4'd0, $urandom, 4'hF);
    end

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].is_wr) beat(0, 1, tbl[i].a, 4'd1, tbl[i].d, tbl[i].b);
      else              single_read($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp);
    end

    // read burst wrapping from DEPTH-2 to 1
    beat(0, 1, 8'd198, 1, 1, 4'hF); beat(0, 1, 8'd199, 1, 2, 4'hF);
    beat(0, 1, 8'd0, 1, 3, 4'hF);   beat(0, 1, 8'd1, 1, 4, 4'hF);
    beat(1, 0, 8'd198, 4'd4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("wrap_wait%0d", i), wq0, (i < 3) ? 1 : 0);
      chk($sformatf("wrap_rdv%0d", i), rdv0, 1);
      chk($sformatf("wrap_dat%0d", i), rdat0, i + 1);
      tick();
    end
    @(negedge clk); chk("wrap_end_rdv", rdv0, 0);
    tick(); tick();

    // write burst of 3 with a 2-cycle stall between beats 1 and 2
    cs = 1; wr = 1; addr = 8'h20; bc = 4'd3; wd = 32'hA0A0_0001; be = 4'hF;
    tick();
    addr = 8'h99; wd = 32'hA0A0_0002;
    tick();
    wr = 0; tick(); tick();
    wr = 1; wd = 32'hA0A0_0003;
    tick();
    go_idle();
    single_read("wstall0", 8'h20, 32'hA0A0_0001);
    single_read("wstall1", 8'h21, 32'hA0A0_0002);
    single_read("wstall2", 8'h22, 32'hA0A0_0003);

    // clken dropped for 3 cycles mid read burst, 2-cycle latency instance
    for (int i = 0; i < 4; i++) beat(0, 1, 8'(8'h50 + i), 1, 32'hC0 + i, 4'hF);
    beat(1, 0, 8'h50, 4'd4, 0, 0);
    exp_cyc = '{5, 6, 7, 8};
    nb = 0;
    for (int c = 1; c <= 12; c++) begin
      clken = !(c >= 2 && c <= 4);
      @(negedge clk);
      if (clken && rdv1) begin
        if (nb < 4) begin
          chk($sformatf("clken_cyc%0d", nb), c, exp_cyc[nb]);
          chk($sformatf("clken_dat%0d", nb), rdat1, 32'hC0 + nb);
        end
        nb++;
      end
      tick();
    end
    clken = 1;
    chk("clken_beats", nb, 4);

    // randomized traffic against the model
    rnd = 1;
    for (int t = 0; t < 150; t++) begin
      int kind, n, eff;
      kind = $urandom_range(0, 9);
      n    = $urandom_range(0, 8);
      eff  = (n == 0) ? 1 : n;
      if (kind < 4) begin
        beat(($urandom_range(0, 3) == 0), 1, 8'($urandom_range(0, DEP - 1)), 4'(n), $urandom, 4'($urandom_range(0, 15)));
        for (int k = 1; k < eff; k++) begin
          repeat ($urandom_range(0, 2)) begin
            clken = ($urandom_range(0, 7) != 0);
            tick();
          end
          beat(0, 1, 8'($urandom), 4'($urandom), $urandom, 4'($urandom_range(0, 15)));
        end
      end else if (kind < 8) begin
        beat(1, 0, 8'($urandom_range(0, DEP - 1)), 4'(n), 0, 0);
      end else begin
        cs = 0; rd = 1'($urandom); wr = 1'($urandom); clken = ($urandom_range(0, 7) != 0);
        tick();
        go_idle();
      end
    end
    rnd = 0;
    go_idle();
    repeat (20) tick();

    // reset in the middle of an 8-beat read burst
    beat(1, 0, 8'h40, 4'd8, 0, 0);
    tick();
    chk("rstmid_before_rdv0", rdv0, 1);
    rst_n = 0;
    #1;
    chk("rstmid_rdv0", rdv0, 0); chk("rstmid_rdv1", rdv1, 0);
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rstmid_after_rdv0", rdv0, 0); chk("rstmid_after_rdv1", rdv1, 0);
      chk("rstmid_after_wait", wq0, 0);
      tick();
    end

`ifdef OCM_PARITY_EN
    par_flip = 1;
    u0.par_q[7][2] = ~u0.par_q[7][2];
    u1.par_q[7][2] = ~u1.par_q[7][2];
    beat(1, 0, 8'd7, 4'd1, 0, 0);
    @(negedge clk);
    chk("par_err0", perr0, 1); chk("par_rdv0", rdv0, 1);
    tick();
    @(negedge clk);
    chk("par_err1", perr1, 1); chk("par_rdv1", rdv1, 1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
